calc_entry_ctrl: RTL and testbench
==================================

Name: calc_entry_ctrl

Overview:
Front-end operand/operator entry controller for the calculator. It synchronises and debounces the raw enter/clear buttons, then sequences capture of operand A, operand B and the operator from the switches. It drives the data bus plus one-cycle load strobes into the downstream `d_flip_flop` operand/operator registers (`d`, `load`, `reset` inputs).

Parameters:
- BITS, 8, operand width; must match downstream register `bits`.
- DB_CYCLES, 4, consecutive disagreeing samples required to accept a button level change. Minimum 1; synthesis overrides to ~500000.

Ports:
- clk  in  1  system clock
- reset  in  1  reset, synchronous, active-high
- sw  in  BITS  operand switches
- op_sw  in  2  operator select (0 ADD, 1 SUB, 2 MUL, 3 DIV)
- btn_enter  in  1  raw asynchronous enter button, active-high
- btn_clear  in  1  raw asynchronous clear button, active-high
- d_out  out  BITS  captured operand to register `d` inputs
- op_out  out  2  captured operator
- load_a  out  1  one-cycle load strobe, operand A register
- load_b  out  1  one-cycle load strobe, operand B register
- load_op  out  1  one-cycle load strobe, operator register
- reg_clear  out  1  one-cycle strobe to downstream register `reset`
- phase  out  2  0 GET_A, 1 GET_B, 2 GET_OP, 3 DONE
- done  out  1  high while in DONE

Behaviour:
- Reset (synchronous, priority over everything):
  - all outputs 0; state GET_A.
  - debouncer sync flops, stable level and counter all 0.
- Button path, per button:
  - 2-flop synchroniser s1→s2.
  - cnt increments on each edge where s2 != stable; cnt clears when s2 == stable.
  - On the edge where s2 != stable and cnt == DB_CYCLES-1: stable <= s2 and cnt <= 0.
  - press is a registered one-cycle pulse, set on the edge where stable rises 0→1. Release produces no pulse.
- Latency, with edge 1 = first edge sampling raw high and the input clean:
  - press is high in the cycle after edge 2+DB_CYCLES.
  - FSM strobes are high in the cycle after edge 3+DB_CYCLES.
- Glitch rule: a raw pulse shorter than DB_CYCLES synchronised samples produces no press.
- FSM, registered outputs, evaluated on press pulses:
  - GET_A + enter: d_out <= sw, load_a 1 cycle, → GET_B.
  - GET_B + enter: d_out <= sw, load_b 1 cycle, → GET_OP.
  - GET_OP + enter: op_out <= op_sw, load_op 1 cycle, → DONE.
  - DONE: done=1. Enter → reg_clear 1 cycle, d_out=0, op_out=0, → GET_A.
  - Clear in any state: reg_clear 1 cycle, d_out=0, op_out=0, → GET_A.
- Simultaneous clear and enter press in the same cycle: clear wins; no load strobe.
- At most one of load_a/load_b/load_op/reg_clear is high in any cycle.
- d_out and op_out hold their value between captures; switch changes are ignored outside capture edges.
- phase and done reflect the current state combinationally from the state register.
- Button held through reset deassert: stable=0, so a press is generated a full debounce period after reset release.
- Reset mid-debounce: the counter is discarded and the debounce restarts from zero.

Decomposition:
- Package calc_pkg holds:
  - phase encodings PH_GET_A=0, PH_GET_B=1, PH_GET_OP=2, PH_DONE=3;
  - operator codes OP_ADD=0, OP_SUB=1, OP_MUL=2, OP_DIV=3.
- Sub-module btn_debounce #(DB_CYCLES): clk, reset, raw → press. Instantiated twice (enter, clear).
- Counter width is clog2(DB_CYCLES)+1.

Test Plan (DB_CYCLES=4):
- Reset, sw=0x25, btn_enter high 10 clean cycles → exactly one load_a, high in the cycle after edge 7; d_out=0x25; phase 0→1; no further strobe while held.
- btn_enter high 3 cycles, then low → no press and no strobe; phase stays 0.
- Full sequence A=0x25, B=0x1C, op_sw=2, three presses → load_a, load_b, load_op once each in order. d_out=0x1C, op_out=2, phase=3, done=1. A fourth enter → reg_clear, phase=0, d_out=0.
- After A and B captured, clear press in GET_OP → reg_clear one cycle, no load_op, phase=0, d_out=0, op_out=0.
- Enter and clear raised on the same cycle, both clean 10 cycles → reg_clear only; no load_a.
- Enter held; reset pulsed 1 cycle after 4 cycles of hold → no press at the original edge 7. Press appears 2+DB_CYCLES edges after reset deasserts, then load_a.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared encodings for the calculator front end: entry phases and operator codes.
package calc_pkg;

   typedef enum logic [1:0] {
      PH_GET_A  = 2'd0,
      PH_GET_B  = 2'd1,
      PH_GET_OP = 2'd2,
      PH_DONE   = 2'd3
   } phase_e;

   localparam logic [1:0] OP_ADD = 2'd0;
   localparam logic [1:0] OP_SUB = 2'd1;
   localparam logic [1:0] OP_MUL = 2'd2;
   localparam logic [1:0] OP_DIV = 2'd3;

endpackage

// File: rtl/btn_debounce.sv
// Synchronises a raw push button, debounces it and emits a one-cycle pulse on
// each accepted press (release edges are silent).
module btn_debounce #(
   parameter int unsigned DB_CYCLES = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic raw,
   output logic press
);

   localparam int unsigned CW = $clog2(DB_CYCLES) + 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

   logic          s1;
   logic          s2;
   logic          stable;
   logic [CW-1:0] cnt;

   // Level is accepted once s2 has disagreed with stable for DB_CYCLES samples in a row.
   always_ff @(posedge clk) begin
      if (reset) begin
         s1     <= 1'b0;
         s2     <= 1'b0;
         stable <= 1'b0;
         cnt    <= '0;
         press  <= 1'b0;
      end else begin
         s1    <= raw;
         s2    <= s1;
         press <= 1'b0;
         if (s2 != stable) begin
            if (cnt == CNT_LAST) begin
               stable <= s2;
               cnt    <= '0;
               press  <= s2;
            end else begin
               cnt <= cnt + CW'(1);
            end
         end else begin
            cnt <= '0;
         end
      end
   end

endmodule

// File: rtl/calc_entry_ctrl.sv
// Operand/operator entry sequencer: debounced enter/clear buttons step through
// A, B and operator capture, strobing the downstream registers one at a time.
module calc_entry_ctrl
   import calc_pkg::*;
#(
   parameter int unsigned BITS      = 8,
   parameter int unsigned DB_CYCLES = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [BITS-1:0] sw,
   input  logic [1:0]      op_sw,
   input  logic            btn_enter,
   input  logic            btn_clear,
   output logic [BITS-1:0] d_out,
   output logic [1:0]      op_out,
   output logic            load_a,
   output logic            load_b,
   output logic            load_op,
   output logic            reg_clear,
   output logic [1:0]      phase,
   output logic            done
);

   phase_e          state;
   phase_e          state_nxt;
   logic            enter_p;
   logic            clear_p;
   logic [BITS-1:0] d_nxt;
   logic [1:0]      op_nxt;
   logic            load_a_nxt;
   logic            load_b_nxt;
   logic            load_op_nxt;
   logic            reg_clear_nxt;

   btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_enter (
      .clk   (clk),
      .reset (reset),
      .raw   (btn_enter),
      .press (enter_p)
   );

   btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_clear (
      .clk   (clk),
      .reset (reset),
      .raw   (btn_clear),
      .press (clear_p)
   );

   // State and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= PH_GET_A;
         d_out     <= '0;
         op_out    <= '0;
         load_a    <= 1'b0;
         load_b    <= 1'b0;
         load_op   <= 1'b0;
         reg_clear <= 1'b0;
      end else begin
         state     <= state_nxt;
         d_out     <= d_nxt;
         op_out    <= op_nxt;
         load_a    <= load_a_nxt;
         load_b    <= load_b_nxt;
         load_op   <= load_op_nxt;
         reg_clear <= reg_clear_nxt;
      end
   end

   // Next state; clear outranks a coincident enter.
   always_comb begin
      state_nxt = state;
      if (clear_p) begin
         state_nxt = PH_GET_A;
      end else if (enter_p) begin
         case (state)
            PH_GET_A:  state_nxt = PH_GET_B;
            PH_GET_B:  state_nxt = PH_GET_OP;
            PH_GET_OP: state_nxt = PH_DONE;
            PH_DONE:   state_nxt = PH_GET_A;
            default:   state_nxt = PH_GET_A;
         endcase
      end
   end

   // Next values of the registered outputs; data holds between captures.
   always_comb begin
      d_nxt         = d_out;
      op_nxt        = op_out;
      load_a_nxt    = 1'b0;
      load_b_nxt    = 1'b0;
      load_op_nxt   = 1'b0;
      reg_clear_nxt = 1'b0;
      if (clear_p) begin
         d_nxt         = '0;
         op_nxt        = '0;
         reg_clear_nxt = 1'b1;
      end else if (enter_p) begin
         case (state)
            PH_GET_A: begin
               d_nxt      = sw;
               load_a_nxt = 1'b1;
            end
            PH_GET_B: begin
               d_nxt      = sw;
               load_b_nxt = 1'b1;
            end
            PH_GET_OP: begin
               op_nxt      = op_sw;
               load_op_nxt = 1'b1;
            end
            default: begin
               d_nxt         = '0;
               op_nxt        = '0;
               reg_clear_nxt = 1'b1;
            end
         endcase
      end
   end

   assign phase = state;
   assign done  = (state == PH_DONE);

endmodule

// File: tb/tb_calc_entry_ctrl.sv
// Self-checking bench for calc_entry_ctrl: table of button presses with a strobe
// scoreboard, plus glitch and reset-during-debounce sequences.
module tb_calc_entry_ctrl;
   import calc_pkg::*;

   localparam int DB = 4;
   localparam int K_A = 0, K_B = 1, K_OP = 2, K_CLR = 3;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] sw = '0;
   logic [1:0] op_sw = '0;
   logic       btn_enter = 1'b0;
   logic       btn_clear = 1'b0;
   logic [7:0] d_out;
   logic [1:0] op_out;
   logic       load_a, load_b, load_op, reg_clear;
   logic [1:0] phase;
   logic       done;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   typedef struct {
      int         kind;
      logic [7:0] d;
      logic [1:0] op;
      int         at;
   } ev_t;

   typedef struct {
      logic [7:0] sw;
      logic [1:0] op;
      logic       en;
      logic       cl;
      int         kind;
      logic [7:0] d;
      logic [1:0] opx;
      logic [1:0] ph;
   } vec_t;

   ev_t  expq[$];
   vec_t vecs[9];

   calc_entry_ctrl #(.BITS(8), .DB_CYCLES(DB)) dut (
      .clk       (clk),
      .reset     (reset),
      .sw        (sw),
      .op_sw     (op_sw),
      .btn_enter (btn_enter),
      .btn_clear (btn_clear),
      .d_out     (d_out),
      .op_out    (op_out),
      .load_a    (load_a),
      .load_b    (load_b),
      .load_op   (load_op),
      .reg_clear (reg_clear),
      .phase     (phase),
      .done      (done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Strobe monitor: every strobe must match the next expected event, on its cycle.
   always @(negedge clk) begin
      if (load_a || load_b || load_op || reg_clear) begin
         int  kind;
         ev_t e;
         kind = load_a ? K_A : load_b ? K_B : load_op ? K_OP : K_CLR;
         chk("strobe_onehot", $countones({load_a, load_b, load_op, reg_clear}), 1);
         if (expq.size() == 0) begin
            chk("unexpected_strobe_kind", kind, -1);
         end else begin
            e = expq.pop_front();
            chk("strobe_kind", kind, e.kind);
            chk("strobe_cycle", cyc, e.at);
            chk("strobe_d_out", int'(d_out), int'(e.d));
            chk("strobe_op_out", int'(op_out), int'(e.op));
         end
      end
   end

   task automatic push_ev(input int kind, input logic [7:0] d, input logic [1:0] op, input int at);
      ev_t e;
      e.kind = kind;
      e.d    = d;
      e.op   = op;
      e.at   = at;
      expq.push_back(e);
   endtask

   task automatic apply_vec(input vec_t v, input int idx);
      @(posedge clk);
      #1;
      sw        = v.sw;
      op_sw     = v.op;
      btn_enter = v.en;
      btn_clear = v.cl;
      push_ev(v.kind, v.d, v.opx, cyc + 3 + DB);
      repeat (10) @(posedge clk);
      #1;
      btn_enter = 1'b0;
      btn_clear = 1'b0;
      repeat (12) @(posedge clk);
      #1;
      chk($sformatf("vec%0d_phase", idx), int'(phase), int'(v.ph));
      chk($sformatf("vec%0d_done", idx), int'(done), int'(v.ph == 2'd3));
      chk($sformatf("vec%0d_d_out", idx), int'(d_out), int'(v.d));
      chk($sformatf("vec%0d_op_out", idx), int'(op_out), int'(v.opx));
   endtask

   initial begin
      vecs[0] = '{8'h25, OP_ADD, 1'b1, 1'b0, K_A,   8'h25, 2'd0,   2'd1};
      vecs[1] = '{8'h1C, OP_ADD, 1'b1, 1'b0, K_B,   8'h1C, 2'd0,   2'd2};
      vecs[2] = '{8'hFF, OP_MUL, 1'b1, 1'b0, K_OP,  8'h1C, OP_MUL, 2'd3};
      vecs[3] = '{8'h55, OP_SUB, 1'b1, 1'b0, K_CLR, 8'h00, 2'd0,   2'd0};
      vecs[4] = '{8'h25, OP_ADD, 1'b1, 1'b0, K_A,   8'h25, 2'd0,   2'd1};
      vecs[5] = '{8'h1C, OP_DIV, 1'b1, 1'b0, K_B,   8'h1C, 2'd0,   2'd2};
      vecs[6] = '{8'h99, OP_DIV, 1'b0, 1'b1, K_CLR, 8'h00, 2'd0,   2'd0};
      vecs[7] = '{8'h77, OP_SUB, 1'b1, 1'b1, K_CLR, 8'h00, 2'd0,   2'd0};
      vecs[8] = '{8'h42, OP_SUB, 1'b0, 1'b1, K_CLR, 8'h00, 2'd0,   2'd0};

      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      chk("reset_phase", int'(phase), 0);
      chk("reset_done", int'(done), 0);
      chk("reset_d_out", int'(d_out), 0);
      chk("reset_op_out", int'(op_out), 0);
      chk("reset_strobes", int'({load_a, load_b, load_op, reg_clear}), 0);

      for (int i = 0; i < 9; i++) apply_vec(vecs[i], i);

      // Pulse one sample short of the debounce window: must be swallowed.
      @(posedge clk);
      #1;
      sw        = 8'hA5;
      btn_enter = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      btn_enter = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      chk("glitch_phase", int'(phase), 0);
      chk("glitch_d_out", int'(d_out), 0);

      // Reset mid-debounce: the press is re-timed from reset release.
      @(posedge clk);
      #1;
      sw        = 8'h3C;
      btn_enter = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      chk("midrst_phase", int'(phase), 0);
      push_ev(K_A, 8'h3C, 2'd0, cyc + 3 + DB);
      repeat (10) @(posedge clk);
      #1;
      btn_enter = 1'b0;
      repeat (12) @(posedge clk);
      #1;
      chk("midrst_phase_after", int'(phase), 1);
      chk("midrst_d_out", int'(d_out), 8'h3C);

      chk("scoreboard_drained", expq.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
